// File: rtl/fp12_mul_issue_if.sv
// fp12_mul_issue_if: request and writeback handshakes of the FP12 multiply issue stage
interface fp12_mul_issue_if #(parameter int TAG_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_x;
  logic [11:0]      in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;
  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_z, out_tag, out_flags
  );
  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_z, out_tag, out_flags
  );
endinterface

// File: rtl/fp12_mul_issue_stage.sv
// fp12_mul_issue_stage: issues operands to a combinational FP12 multiplier, waits LATENCY
// cycles, then captures the product with zero/overflow/underflow repaired for writeback.
module fp12_mul_issue_stage #(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  fp12_mul_issue_if.slave     bus,
  output logic [11:0]         mul_x,
  output logic [11:0]         mul_y,
  input  logic [11:0]         mul_z
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [TAG_W-1:0]  tag;
  logic              s;
  logic              norm;
  logic              zero_in;
  logic signed [5:0] esum;
  logic signed [5:0] etrue;
  logic [11:0]       fix_z;
  logic [2:0]        fix_f;
  // the multiplier's exponent field only moves off esum when the mantissa product normalised
  always_comb begin
    s       = mul_x[11] ^ mul_y[11];
    esum    = $signed({2'b00, mul_x[10:7]} + {2'b00, mul_y[10:7]} - 6'd7);
    norm    = mul_z[10:7] != esum[3:0];
    etrue   = esum + $signed({5'b00000, norm});
    zero_in = (mul_x[10:0] == 11'h000) | (mul_y[10:0] == 11'h000);
    fix_z   = zero_in        ? {s, 11'h000} :
              etrue > 6'sd15 ? {s, 11'h7FF} :
              etrue < 6'sd0  ? {s, 11'h000} : mul_z;
    fix_f   = zero_in        ? 3'b001 :
              etrue > 6'sd15 ? 3'b100 :
              etrue < 6'sd0  ? 3'b011 : {2'b00, mul_z[10:0] == 11'h000};
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tag           <= '0;
      mul_x         <= '0;
      mul_y         <= '0;
      bus.out_z     <= '0;
      bus.out_tag   <= '0;
      bus.out_flags <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          mul_x <= bus.in_x;
          mul_y <= bus.in_y;
          tag   <= bus.in_tag;
          cnt   <= CW'(LATENCY - 1);
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          bus.out_z     <= fix_z;
          bus.out_tag   <= tag;
          bus.out_flags <= fix_f;
          state         <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp12_mul_issue_stage.sv
// tb_fp12_mul_issue_stage: randomized and directed checks of the FP12 issue stage
// against an arithmetic reference model, with LATENCY=1 and LATENCY=3 instances.
module tb_fp12_mul_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0, rdy = 1'b0, sel = 1'b0;
  logic [11:0] dx = '0, dy = '0;
  logic [3:0]  dt = '0;
  logic [11:0] mx1, my1, mz1, mx3, my3, mz3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fp12_mul_issue_if #(.TAG_W(4)) b1 ();
  fp12_mul_issue_if #(.TAG_W(4)) b3 ();

  fp12_mul_issue_stage #(.LATENCY(1), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .mul_x(mx1), .mul_y(my1), .mul_z(mz1));
  fp12_mul_issue_stage #(.LATENCY(3), .TAG_W(4)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .mul_x(mx3), .mul_y(my3), .mul_z(mz3));

  // external combinational multiplier: truncating, exponent field wraps mod 16
  function automatic logic [11:0] fmul(input logic [11:0] a, input logic [11:0] b);
    logic [15:0] p;
    logic [4:0]  e;
    p = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    e = 5'({1'b0, a[10:7]} + {1'b0, b[10:7]} + {4'b0000, p[15]} - 5'd7);
    return {a[11] ^ b[11], e[3:0], p[15] ? p[14:8] : p[13:7]};
  endfunction

  assign mz1 = fmul(mx1, my1);
  assign mz3 = fmul(mx3, my3);

  assign b1.in_valid  = v & ~sel;
  assign b3.in_valid  = v & sel;
  assign b1.out_ready = rdy & ~sel;
  assign b3.out_ready = rdy & sel;
  assign b1.in_x = dx;
  assign b1.in_y = dy;
  assign b1.in_tag = dt;
  assign b3.in_x = dx;
  assign b3.in_y = dy;
  assign b3.in_tag = dt;

  wire        o_ready = sel ? b3.in_ready  : b1.in_ready;
  wire        o_valid = sel ? b3.out_valid : b1.out_valid;
  wire [11:0] o_z     = sel ? b3.out_z     : b1.out_z;
  wire [3:0]  o_tag   = sel ? b3.out_tag   : b1.out_tag;
  wire [2:0]  o_flags = sel ? b3.out_flags : b1.out_flags;

  // reference: real product value from mantissas and exponents
  function automatic void ref_mul(input logic [11:0] x, input logic [11:0] y,
                                  output logic [11:0] z, output logic [2:0] f);
    int p, n, e, fr;
    logic s;
    s  = x[11] ^ y[11];
    p  = (128 + int'(x[6:0])) * (128 + int'(y[6:0]));
    n  = (p >= 32768) ? 1 : 0;
    e  = int'(x[10:7]) + int'(y[10:7]) - 7 + n;
    fr = (p >> (7 + n)) % 128;
    if (x[10:0] == 11'h000 || y[10:0] == 11'h000) begin z = {s, 11'h000}; f = 3'b001; end
    else if (e > 15) begin z = {s, 11'h7FF}; f = 3'b100; end
    else if (e < 0)  begin z = {s, 11'h000}; f = 3'b011; end
    else begin
      z = {s, 4'(e), 7'(fr)};
      f = {2'b00, z[10:0] == 11'h000};
    end
  endfunction

  task automatic run_op(input logic [11:0] x, input logic [11:0] y, input logic [3:0] t,
                        output logic [11:0] z, output logic [3:0] ot, output logic [2:0] f,
                        output int lat);
    int w = 0;
    @(negedge clk);
    while (!o_ready && w < 50) begin @(negedge clk); w++; end
    dx = x; dy = y; dt = t; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    lat = 0;
    while (!o_valid && lat < 50) begin @(negedge clk); lat++; end
    z = o_z; ot = o_tag; f = o_flags;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (b1.in_ready !== 1'b1 || b3.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b/%b exp 1/1", b1.in_ready, b3.in_ready); end
    checks++; if (b1.out_valid !== 1'b0 || b3.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b/%b exp 0/0", b1.out_valid, b3.out_valid); end
    checks++; if ({mx1, my1, mx3, my3} !== 48'h0) begin errors++;
      $display("FAIL reset_mul_ops got %h exp 0", {mx1, my1, mx3, my3}); end
    checks++; if ({b1.out_z, b1.out_tag, b1.out_flags} !== 19'h0) begin errors++;
      $display("FAIL reset_out got %h exp 0", {b1.out_z, b1.out_tag, b1.out_flags}); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [11:0] xs [6] = '{12'h3C0, 12'h3C0, 12'h800, 12'h000, 12'h7C0, 12'h080};
    logic [11:0] ys [6] = '{12'h400, 12'h3C0, 12'h3C0, 12'hBC0, 12'h7C0, 12'h080};
    logic [11:0] ez [6] = '{12'h440, 12'h410, 12'h800, 12'h800, 12'h7FF, 12'h000};
    logic [2:0]  ef [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b011};
    logic [11:0] z;
    logic [3:0]  t;
    logic [2:0]  f;
    int lat;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], ys[i], 4'(i + 5), z, t, f, lat);
      checks++; if (z !== ez[i]) begin errors++;
        $display("FAIL dir_z[%0d] got %h exp %h", i, z, ez[i]); end
      checks++; if (f !== ef[i]) begin errors++;
        $display("FAIL dir_flags[%0d] got %b exp %b", i, f, ef[i]); end
      checks++; if (t !== 4'(i + 5)) begin errors++;
        $display("FAIL dir_tag[%0d] got %h exp %h", i, t, 4'(i + 5)); end
      checks++; if (lat !== 1) begin errors++;
        $display("FAIL dir_latency[%0d] got %0d exp 1", i, lat); end
    end
  endtask

  task automatic test_random(input logic which, input int n);
    logic [11:0] x, y, z, ez;
    logic [3:0]  t, ot;
    logic [2:0]  f, ef;
    int lat;
    sel = which;
    for (int i = 0; i < n; i++) begin
      x = 12'($urandom); y = 12'($urandom); t = 4'($urandom);
      if (i % 8 == 0) x[10:0] = 11'h000;
      ref_mul(x, y, ez, ef);
      run_op(x, y, t, z, ot, f, lat);
      checks++; if (z !== ez || f !== ef || ot !== t) begin errors++;
        $display("FAIL rand_L%0d x=%h y=%h got z=%h f=%b t=%h exp z=%h f=%b t=%h",
                 which ? 3 : 1, x, y, z, f, ot, ez, ef, t); end
      checks++; if (lat !== (which ? 3 : 1)) begin errors++;
        $display("FAIL rand_latency got %0d exp %0d", lat, which ? 3 : 1); end
    end
  endtask

  task automatic test_hold;
    logic [11:0] x, y, ez;
    logic [2:0]  ef;
    int w = 0;
    sel = 1'b0;
    x = 12'h3A5; y = 12'h41C;
    ref_mul(x, y, ez, ef);
    @(negedge clk);
    dx = x; dy = y; dt = 4'hB; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    while (!o_valid && w < 20) begin @(negedge clk); w++; end
    for (int i = 0; i < 5; i++) begin
      v = i[0];
      dx = 12'($urandom); dy = 12'($urandom); dt = 4'($urandom);
      @(negedge clk);
      checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_z !== ez || o_flags !== ef || o_tag !== 4'hB)
        begin errors++;
        $display("FAIL hold[%0d] got v=%b r=%b z=%h f=%b t=%h exp v=1 r=0 z=%h f=%b t=b",
                 i, o_valid, o_ready, o_z, o_flags, o_tag, ez, ef); end
    end
    v = 1'b1; rdy = 1'b1;
    @(negedge clk);
    v = 1'b0; rdy = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", o_valid, o_ready); end
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++;
      $display("FAIL release_no_accept got r=%b exp 1", o_ready); end
  endtask

  task automatic test_reset_mid;
    logic [11:0] z, ez;
    logic [3:0]  t;
    logic [2:0]  f, ef;
    int lat, seen = 0;
    sel = 1'b1;
    @(negedge clk);
    dx = 12'h3C0; dy = 12'h400; dt = 4'h9; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (b3.out_valid !== 1'b0 || b3.in_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_hs got v=%b r=%b exp v=0 r=1", b3.out_valid, b3.in_ready); end
    checks++; if ({mx3, my3, b3.out_z, b3.out_tag, b3.out_flags} !== 43'h0) begin errors++;
      $display("FAIL midrst_regs got %h exp 0", {mx3, my3, b3.out_z, b3.out_tag, b3.out_flags}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (o_valid) seen++; end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL midrst_discard got %0d valid cycles exp 0", seen); end
    ref_mul(12'hC55, 12'h3D3, ez, ef);
    run_op(12'hC55, 12'h3D3, 4'h6, z, t, f, lat);
    checks++; if (z !== ez || f !== ef || t !== 4'h6 || lat !== 3) begin errors++;
      $display("FAIL midrst_next got z=%h f=%b t=%h lat=%0d exp z=%h f=%b t=6 lat=3",
               z, f, t, lat, ez, ef); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] ez;
    logic [2:0]  ef;
    int done = 0, bad = 0;
    sel = 1'b0;
    dx = 12'h452; dy = 12'hB31; dt = 4'h3;
    ref_mul(dx, dy, ez, ef);
    @(negedge clk);
    v = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_valid) begin
        done++;
        if (o_ready || o_z !== ez || o_flags !== ef || o_tag !== 4'h3) bad++;
      end
    end
    v = 1'b0; rdy = 1'b0;
    checks++; if (done !== 10) begin errors++;
      $display("FAIL b2b_count got %0d exp 10", done); end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL b2b_results got %0d bad exp 0", bad); end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random(1'b0, 40);
    test_random(1'b1, 20);
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
